// File: rtl/pc_stack_if.sv
// Handshake/status bundle between the program sequencer and the return-address stack.
interface pc_stack_if #(
  parameter int W     = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          enable;
  logic          push;
  logic          pop;
  logic [W-1:0]  push_pc;
  logic          err_clr;
  logic [W-1:0]  top;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  modport master (
    output enable, push, pop, push_pc, err_clr,
    input  top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  enable, push, pop, push_pc, err_clr,
    output top, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/pc_stack_ctrl.sv
// Return-address LIFO for the program sequencer: CALL pushes, RET pops,
// simultaneous push+pop replaces the top (tail call). Sticky over/underflow flags.
module pc_stack_ctrl #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  pc_stack_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  entry [DEPTH];
  logic [CW-1:0] sp;
  logic          ovf_q;
  logic          unf_q;

  logic          is_empty;
  logic          is_full;
  logic          wr_en;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] sp_nxt;
  logic          ovf_set;
  logic          unf_set;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == CW'(DEPTH));

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sp;
    sp_nxt  = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en  = 1'b1;
          sp_nxt = sp + CW'(1);
        end
      end
      2'b01: begin
        if (is_empty) unf_set = 1'b1;
        else          sp_nxt  = sp - CW'(1);
      end
      2'b11: begin
        // Tail call overwrites the top; on an empty stack it degenerates to a push.
        wr_en = 1'b1;
        if (is_empty) sp_nxt = CW'(1);
        else          wr_idx = sp - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (bus.enable) begin
      sp <= sp_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_idx == CW'(i)) entry[i] <= bus.push_pc;
      end
      // A set event on the same edge as err_clr must win.
      if (bus.err_clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  always_comb begin
    bus.top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sp == CW'(i + 1)) bus.top = entry[i];
    end
  end

  assign bus.count     = sp;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Self-checking bench: directed vector table for the corner cases, then random
// traffic against a queue-based LIFO model.
module tb_pc_stack_ctrl;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_stack_if #(.W(W), .DEPTH(DEPTH)) bus ();

  pc_stack_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          r, en, pu, po, ec;
    logic [W-1:0]  pc;
    logic [W-1:0]  top;
    logic [CW-1:0] cnt;
    logic          emp, ful, ov, un;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Add one vector; empty/full are derived from the expected count.
  task automatic v(input logic r, en, pu, po, ec, input logic [W-1:0] pc,
                   input logic [W-1:0] t, input int c, input logic ov, un);
    vec_t x;
    x.r = r; x.en = en; x.pu = pu; x.po = po; x.ec = ec; x.pc = pc;
    x.top = t; x.cnt = CW'(c); x.emp = (c == 0); x.ful = (c == DEPTH);
    x.ov = ov; x.un = un;
    vt.push_back(x);
  endtask

  task automatic drive_step(input logic r, en, pu, po, ec, input logic [W-1:0] pc);
    @(negedge clk);
    reset = r; bus.enable = en; bus.push = pu; bus.pop = po;
    bus.err_clr = ec; bus.push_pc = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] t, input logic [CW-1:0] c,
                               input logic e, f, ov, un);
    chk({tag, ".top"},       64'(bus.top),       64'(t));
    chk({tag, ".count"},     64'(bus.count),     64'(c));
    chk({tag, ".empty"},     64'(bus.empty),     64'(e));
    chk({tag, ".full"},      64'(bus.full),      64'(f));
    chk({tag, ".overflow"},  64'(bus.overflow),  64'(ov));
    chk({tag, ".underflow"}, 64'(bus.underflow), 64'(un));
  endtask

  // Reference model state
  logic [W-1:0] mq[$];
  logic         m_ov, m_un;

  task automatic model_step(input logic r, en, pu, po, ec, input logic [W-1:0] pc);
    logic sov, sun;
    sov = 1'b0; sun = 1'b0;
    if (r) begin
      mq.delete(); m_ov = 1'b0; m_un = 1'b0;
    end else if (en) begin
      if (pu && po) begin
        if (mq.size() == 0) mq.push_back(pc);
        else mq[mq.size()-1] = pc;
      end else if (pu) begin
        if (mq.size() < DEPTH) mq.push_back(pc);
        else sov = 1'b1;
      end else if (po) begin
        if (mq.size() > 0) void'(mq.pop_back());
        else sun = 1'b1;
      end
      if (ec) begin m_ov = 1'b0; m_un = 1'b0; end
      if (sov) m_ov = 1'b1;
      if (sun) m_un = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; bus.enable = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    bus.err_clr = 1'b0; bus.push_pc = '0;

    // Basic push/pop ordering
    v(1,0,0,0,0, 0,      0,     0, 0,0);
    v(0,1,1,0,0, 'h100,  'h100, 1, 0,0);
    v(0,1,1,0,0, 'h200,  'h200, 2, 0,0);
    v(0,1,1,0,0, 'h300,  'h300, 3, 0,0);
    v(0,1,0,1,0, 0,      'h200, 2, 0,0);
    v(0,1,0,1,0, 0,      'h100, 1, 0,0);
    v(0,1,0,1,0, 0,      0,     0, 0,0);
    // Fill, overflow, pop keeps sticky, err_clr clears
    for (int i = 0; i < DEPTH; i++) v(0,1,1,0,0, 'h10+i, 'h10+i, i+1, 0,0);
    v(0,1,1,0,0, 'h99, 'h17, 8, 1,0);
    v(0,1,0,1,0, 0,    'h16, 7, 1,0);
    v(0,1,0,0,1, 0,    'h16, 7, 0,0);
    // Underflow; set beats a simultaneous err_clr
    v(1,1,0,0,0, 0, 0, 0, 0,0);
    v(0,1,0,1,0, 0, 0, 0, 0,1);
    v(0,1,0,1,1, 0, 0, 0, 0,1);
    v(0,1,0,0,1, 0, 0, 0, 0,0);
    // Tail call, then push+pop on empty
    v(1,1,0,0,0, 0,   0,   0, 0,0);
    v(0,1,1,0,0, 'hA, 'hA, 1, 0,0);
    v(0,1,1,0,0, 'hB, 'hB, 2, 0,0);
    v(0,1,1,1,0, 'hC, 'hC, 2, 0,0);
    v(0,1,0,1,0, 0,   'hA, 1, 0,0);
    v(0,1,0,1,0, 0,   0,   0, 0,0);
    v(0,1,1,1,0, 'hD, 'hD, 1, 0,0);
    // Stall ignores push/pop/err_clr; underflow held across it
    v(1,1,0,0,0, 0,   0,   0, 0,0);
    v(0,1,0,1,0, 0,   0,   0, 0,1);
    v(0,1,1,0,0, 'h1, 'h1, 1, 0,1);
    v(0,1,1,0,0, 'h2, 'h2, 2, 0,1);
    v(0,1,1,0,0, 'h3, 'h3, 3, 0,1);
    v(0,0,1,0,0, 'h44,'h3, 3, 0,1);
    v(0,0,0,1,0, 0,   'h3, 3, 0,1);
    v(0,0,1,1,1, 'h44,'h3, 3, 0,1);
    v(0,1,0,1,0, 0,   'h2, 2, 0,1);
    // Reset dominates a push with 5 entries and overflow set
    v(1,1,0,0,0, 0, 0, 0, 0,0);
    for (int i = 0; i < DEPTH; i++) v(0,1,1,0,0, 'h50+i, 'h50+i, i+1, 0,0);
    v(0,1,1,0,0, 'h77, 'h57, 8, 1,0);
    v(0,1,0,1,0, 0, 'h56, 7, 1,0);
    v(0,1,0,1,0, 0, 'h55, 6, 1,0);
    v(0,1,0,1,0, 0, 'h54, 5, 1,0);
    v(1,1,1,0,0, 'h88, 0, 0, 0,0);

    foreach (vt[k]) begin
      drive_step(vt[k].r, vt[k].en, vt[k].pu, vt[k].po, vt[k].ec, vt[k].pc);
      check_outputs($sformatf("vec%0d", k), vt[k].top, vt[k].cnt,
                    vt[k].emp, vt[k].ful, vt[k].ov, vt[k].un);
    end

    // Random traffic against the model; push bias alternates so both ends are reached
    mq.delete(); m_ov = 1'b0; m_un = 1'b0;
    drive_step(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3000; i++) begin
      logic r, en, pu, po, ec;
      logic [W-1:0] pc;
      int bias;
      bias = ((i / 150) % 2 == 0) ? 70 : 30;
      r  = ($urandom_range(99) < 2);
      en = ($urandom_range(99) < 85);
      pu = ($urandom_range(99) < bias);
      po = ($urandom_range(99) < (100 - bias));
      ec = ($urandom_range(99) < 8);
      pc = $urandom;
      drive_step(r, en, pu, po, ec, pc);
      model_step(r, en, pu, po, ec, pc);
      check_outputs($sformatf("rnd%0d", i),
                    (mq.size() > 0) ? mq[mq.size()-1] : '0,
                    CW'(mq.size()), mq.size() == 0, mq.size() == DEPTH, m_ov, m_un);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
